// File: rtl/fie_bram_block.sv
// Dual-port LMB BRAM with a fault-injection engine that XOR-flips a mask into one word.
// The injection read/write borrows port B whenever the processor leaves it idle.

module fie_bram_lane #(
    parameter int DEPTH = 8192,
    parameter int AB    = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_a,
    input  logic          we_a,
    input  logic [AB-1:0] addr_a,
    input  logic [7:0]    wd_a,
    input  logic          en_b,
    input  logic          we_b,
    input  logic          ld_b,
    input  logic [AB-1:0] addr_b,
    input  logic [7:0]    wd_b,
    output logic [7:0]    q_a,
    output logic [7:0]    q_b,
    output logic [7:0]    rd_b
);
    logic [7:0] mem [DEPTH];
    logic       wa, wb, coll;

    assign wa   = en_a & we_a;
    assign wb   = en_b & we_b;
    assign coll = wb && (addr_a == addr_b);
    assign rd_b = mem[addr_b];

    // B is written last so it wins a same-lane collision.
    always_ff @(posedge clk) begin
        if (wa) mem[addr_a] <= wd_a;
        if (wb) mem[addr_b] <= wd_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (en_a) q_a <= wa ? (coll ? wd_b : wd_a) : mem[addr_a];
            if (ld_b) q_b <= wb ? wd_b : mem[addr_b];
        end
    end
endmodule

module fie_bram_block #(
    parameter int C_MEMSIZE      = 'h8000,
    parameter int C_PORT_DWIDTH  = 32,
    parameter int C_PORT_AWIDTH  = 32,
    parameter int C_NUM_WE       = 4,
    parameter int C_FI_CNT_WIDTH = 16,
    parameter     C_FAMILY       = "virtex6"
) (
    input  logic                       BRAM_Clk,
    input  logic                       BRAM_Rst,
    input  logic                       BRAM_EN_A,
    input  logic [0:C_NUM_WE-1]        BRAM_WEN_A,
    input  logic [0:C_PORT_AWIDTH-1]   BRAM_Addr_A,
    input  logic [0:C_PORT_DWIDTH-1]   BRAM_Dout_A,
    output logic [0:C_PORT_DWIDTH-1]   BRAM_Din_A,
    input  logic                       BRAM_EN_B,
    input  logic [0:C_NUM_WE-1]        BRAM_WEN_B,
    input  logic [0:C_PORT_AWIDTH-1]   BRAM_Addr_B,
    input  logic [0:C_PORT_DWIDTH-1]   BRAM_Dout_B,
    output logic [0:C_PORT_DWIDTH-1]   BRAM_Din_B,
    input  logic                       FI_Req,
    input  logic [0:C_PORT_AWIDTH-1]   FI_Addr,
    input  logic [0:C_PORT_DWIDTH-1]   FI_Mask,
    output logic                       FI_Busy,
    output logic                       FI_Done,
    output logic [0:C_PORT_DWIDTH-1]   FI_Old,
    output logic [0:C_FI_CNT_WIDTH-1]  FI_Count
);
    localparam int DEPTH = C_MEMSIZE / C_NUM_WE;
    localparam int AB    = $clog2(DEPTH);
    localparam int LW    = $clog2(C_NUM_WE);
    localparam int AW    = C_PORT_AWIDTH;
    localparam int DW    = C_PORT_DWIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [AW-1:0]             addr_a_d, addr_b_d, fi_addr_d;
    logic [AB-1:0]             idx_a, idx_b, fi_idx, b_addr;
    logic [1:0]                state;
    logic [0:DW-1]             fi_mask, fi_data, fi_wdata, raw_b, b_wd;
    logic [0:C_NUM_WE-1]       b_we;
    logic [C_FI_CNT_WIDTH-1:0] fi_cnt;
    logic                      dirty, hit, fi_rd, fi_try, fi_we, b_en;
    logic                      unused_ok;

    // Descending copies so word-index bits can be sliced LSB-first.
    assign addr_a_d  = BRAM_Addr_A;
    assign addr_b_d  = BRAM_Addr_B;
    assign fi_addr_d = FI_Addr;
    assign idx_a     = addr_a_d[LW +: AB];
    assign idx_b     = addr_b_d[LW +: AB];
    assign unused_ok = ^{addr_a_d, addr_b_d, fi_addr_d, C_FAMILY};

    assign hit = (BRAM_EN_A && |BRAM_WEN_A && idx_a == fi_idx) ||
                 (BRAM_EN_B && |BRAM_WEN_B && idx_b == fi_idx);

    assign fi_rd    = (state == S_RD) && !BRAM_EN_B;
    assign fi_try   = (state == S_WR) && !BRAM_EN_B;
    assign fi_we    = fi_try && !dirty && !hit && !BRAM_Rst;
    assign fi_wdata = fi_data ^ fi_mask;

    // Port B is handed to the injector only while the processor leaves it idle.
    assign b_en   = BRAM_EN_B | fi_we;
    assign b_we   = BRAM_EN_B ? BRAM_WEN_B  : {C_NUM_WE{fi_we}};
    assign b_addr = BRAM_EN_B ? idx_b       : fi_idx;
    assign b_wd   = BRAM_EN_B ? BRAM_Dout_B : fi_wdata;

    for (genvar i = 0; i < C_NUM_WE; i++) begin : g_lane
        fie_bram_lane #(.DEPTH(DEPTH), .AB(AB)) u_lane (
            .clk    (BRAM_Clk),
            .rst    (BRAM_Rst),
            .en_a   (BRAM_EN_A),
            .we_a   (BRAM_WEN_A[i]),
            .addr_a (idx_a),
            .wd_a   (BRAM_Dout_A[i*8 +: 8]),
            .en_b   (b_en),
            .we_b   (b_we[i]),
            .ld_b   (BRAM_EN_B),
            .addr_b (b_addr),
            .wd_b   (b_wd[i*8 +: 8]),
            .q_a    (BRAM_Din_A[i*8 +: 8]),
            .q_b    (BRAM_Din_B[i*8 +: 8]),
            .rd_b   (raw_b[i*8 +: 8])
        );
    end

    always_ff @(posedge BRAM_Clk) begin
        if (BRAM_Rst) begin
            state   <= S_IDLE;
            dirty   <= 1'b0;
            fi_idx  <= '0;
            fi_mask <= '0;
            fi_data <= '0;
            FI_Old  <= '0;
            fi_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: if (FI_Req) begin
                    fi_idx  <= fi_addr_d[AB-1:0];
                    fi_mask <= FI_Mask;
                    state   <= S_RD;
                end
                S_RD: if (fi_rd) begin
                    fi_data <= raw_b;
                    dirty   <= hit;   // a write racing the read leaves fi_data stale
                    state   <= S_WR;
                end
                S_WR: begin
                    if (BRAM_EN_B) begin
                        dirty <= dirty | hit;
                    end else if (dirty || hit) begin
                        state <= S_RD;
                    end else begin
                        FI_Old <= fi_data;
                        if (fi_cnt != {C_FI_CNT_WIDTH{1'b1}}) fi_cnt <= fi_cnt + 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign FI_Busy  = (state == S_RD) || (state == S_WR);
    assign FI_Done  = (state == S_DONE);
    assign FI_Count = fi_cnt;
endmodule

// File: doc/fie_bram_block.md
# fie_bram_block

Parametrised dual-port local-memory BRAM block for the MicroBlaze LMB instruction/data ports. It adds a fault-injection port that XOR-flips a selected bit mask in one stored word by an atomic read-modify-write. The write is borrowed from port B's idle cycles, so processor accesses are never stalled. It sits between the two LMB BRAM interface controllers and the fault-injection engine.

## Interface
- C_MEMSIZE, 'h8000, memory size in bytes; power of two, ≥ 4·C_NUM_WE.
- C_PORT_DWIDTH, 32, data width; multiple of 8, 32 or 64.
- C_PORT_AWIDTH, 32, byte-address width.
- C_NUM_WE, 4, byte-lane write enables; must equal C_PORT_DWIDTH/8.
- C_FI_CNT_WIDTH, 16, width of completed-injection counter.
- C_FAMILY, "virtex6", target family string; no functional effect.

Ports (vectors use [0:N-1] numbering; bit 0 is the MSB; lane 0 is bits 0..7):
- BRAM_Clk  in  1  single clock for both ports and injection logic.
- BRAM_Rst  in  1  synchronous, active-high reset.
- BRAM_EN_A / BRAM_EN_B  in  1  port access enable.
- BRAM_WEN_A / BRAM_WEN_B  in  C_NUM_WE  byte-lane write enables; valid only with EN.
- BRAM_Addr_A / BRAM_Addr_B  in  C_PORT_AWIDTH  byte address.
- BRAM_Dout_A / BRAM_Dout_B  in  C_PORT_DWIDTH  write data from controller.
- BRAM_Din_A / BRAM_Din_B  out  C_PORT_DWIDTH  registered read data to controller.
- FI_Req  in  1  injection request, sampled in IDLE only.
- FI_Addr  in  C_PORT_AWIDTH  word index of target (not byte address).
- FI_Mask  in  C_PORT_DWIDTH  XOR mask.
- FI_Busy  out  1  injection in progress.
- FI_Done  out  1  one-cycle pulse: injection written.
- FI_Old  out  C_PORT_DWIDTH  word value before the last completed injection.
- FI_Count  out  C_FI_CNT_WIDTH  completed injections; saturating.

## Operation
- Depth D = C_MEMSIZE/C_NUM_WE words.
- Port word index = (byte address / C_NUM_WE) mod D; the upper address bits wrap.
- FI word index = FI_Addr mod D.
- Contents are not cleared by reset.
- Port access, EN=1:
  - Each lane with WEN set is written.
  - Din is updated to the word with the written lanes showing new data (write-first); unwritten lanes show the prior contents.
  - With EN=0, Din holds its value.
- Same word, same cycle, both ports writing: for overlapping lanes port B wins. Each port's Din shows the final stored word for lanes it wrote and prior contents for the others.
- Injection FSM, states IDLE, RD, WR, DONE:
  - IDLE: when FI_Req=1, capture FI_Addr and FI_Mask, then go to RD.
  - RD: when BRAM_EN_B=0, read the target into the internal register, then go to WR. Otherwise stay in RD. BRAM_Din_B is not affected.
  - WR: when BRAM_EN_B=0 and no retry condition holds, write stored^mask to all lanes, then go to DONE. When EN_B=1, stay in WR.
  - Retry condition: any A or B write (any lane) to the target word in the RD-exit cycle, or in any cycle from then through the would-be write cycle. On retry, return to RD and do not write. This keeps the XOR applied to fresh data.
  - DONE: pulse FI_Done, load FI_Old with the pre-XOR word, increment FI_Count (holds at all-ones), then go to IDLE.
- FI_Req in any state other than IDLE is ignored. A mask of all zeros still performs the full sequence and counts.
- FI_Busy = 1 in RD and WR.
- Reset mid-injection: the FSM goes to IDLE, no write occurs, and there is no Done pulse.

## Timing
- Read latency is 1 cycle: with EN at edge t, Din is valid after edge t+1 and held until the next enabled access.
- Best-case injection:
  - FI_Req sampled at edge t.
  - RD completes at edge t+1.
  - Write commits at edge t+2.
  - FI_Done is high for cycle t+2..t+3.
  - A new request is accepted at edge t+4.
- Reset values: BRAM_Din_A=0, BRAM_Din_B=0, FI_Busy=0, FI_Done=0, FI_Old=0, FI_Count=0, FSM=IDLE.
- A port-A read in the injection write cycle returns the pre-injection word. The injected word is visible from the next access.

## Test plan
- Write 0xDEADBEEF to A addr 0x10 with WEN=1111. Next cycle, read on B addr 0x10 → Din_B=0xDEADBEEF after 1 cycle. WEN=0100 write 0x00AA0000 → word 0xDEAABEEF.
- Injection: FI_Req with FI_Addr=4 and mask 0x00000001 on word 0x12345678, port B idle → FI_Done at t+2, word=0x12345679, FI_Old=0x12345678, FI_Count=1.
- Hold BRAM_EN_B=1 for 10 cycles after FI_Req → FI_Busy stays 1 with no write. Once B is idle, injection completes 2 cycles later.
- Port A writes 0xFFFFFFFF to the target word during the RD-exit cycle → retry. The final word is 0xFFFFFFFE for mask 0x00000001.
- Simultaneous A/B writes to the same word: A=0x11111111, B=0x22222222, all lanes → word=0x22222222. Address 0x8000+0x10 aliases to 0x10.
- Assert BRAM_Rst while in WR → no write, FI_Done stays 0, all outputs return to reset values, and memory retains its contents. With C_FI_CNT_WIDTH=2, 5 injections → FI_Count=3.
